// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and constants for the serial add/sub arbiter
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int   CHUNK_W = 3;
   localparam logic OP_ADD  = 1'b0;
   localparam logic OP_SUB  = 1'b1;

endpackage

// File: rtl/addsub_chunk.sv
// rtl/addsub_chunk.sv - combinational 3-bit add/sub slice with carry-in and carry into MSB
module addsub_chunk
   import addsub_pkg::*;
(
   input  logic [CHUNK_W-1:0] a_i,
   input  logic [CHUNK_W-1:0] b_i,
   input  logic               sub_i,
   input  logic               cin_i,
   output logic [CHUNK_W-1:0] z_o,
   output logic               cout_o,
   output logic               c_msb_o
);

   logic [CHUNK_W-1:0] b_x;
   logic [CHUNK_W:0]   sum;

   assign b_x     = (sub_i == OP_SUB) ? ~b_i : b_i;
   assign sum     = {1'b0, a_i} + {1'b0, b_x} + {{CHUNK_W{1'b0}}, cin_i};
   assign z_o     = sum[CHUNK_W-1:0];
   assign cout_o  = sum[CHUNK_W];
   // Carry into the top bit, recovered from the top sum bit and its two inputs.
   assign c_msb_o = a_i[CHUNK_W-1] ^ b_x[CHUNK_W-1] ^ sum[CHUNK_W-1];

endmodule

// File: rtl/addsub_seq_arb.sv
// rtl/addsub_seq_arb.sv - round-robin arbiter sharing one serial 3-bit add/sub chunk; OVF_DETECT_EN adds res_ovf
module addsub_seq_arb
   import addsub_pkg::*;
#(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_sub,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_sub,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_id,
   output logic [WIDTH-1:0] res_z,
   output logic             res_cout,
`ifdef OVF_DETECT_EN
   output logic             res_ovf,
`endif
   output logic             busy
);

   localparam int N_CHUNK = WIDTH / CHUNK_W;
   localparam int IDX_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNK - 1);

   state_e             state_q;
   logic [WIDTH-1:0]   a_q, b_q, z_q;
   logic [IDX_W-1:0]   idx_q;
   logic               sub_q, id_q, carry_q, cout_q, valid_q, busy_q, prio_q;

   logic               grant;
   logic [WIDTH-1:0]   acc_a_d, acc_b_d, z_d;
   logic               acc_sub_d;
   logic [WIDTH+CHUNK_W-1:0] z_ext;

   logic [CHUNK_W-1:0] chunk_z;
   logic               chunk_cout, chunk_c_msb;

   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) grant = prio_q;
      else                          grant = req1_valid;
   end

   assign req0_ready = rst_n && (state_q == IDLE) && !grant && req0_valid;
   assign req1_ready = rst_n && (state_q == IDLE) &&  grant && req1_valid;

   assign acc_a_d   = grant ? req1_a   : req0_a;
   assign acc_b_d   = grant ? req1_b   : req0_b;
   assign acc_sub_d = grant ? req1_sub : req0_sub;

   // Result fills from the top: after N_CHUNK shifts chunk 0 lands in the low bits.
   assign z_ext = {chunk_z, z_q};
   assign z_d   = z_ext[WIDTH+CHUNK_W-1:CHUNK_W];

   addsub_chunk u_chunk (
      .a_i     (a_q[CHUNK_W-1:0]),
      .b_i     (b_q[CHUNK_W-1:0]),
      .sub_i   (sub_q),
      .cin_i   (carry_q),
      .z_o     (chunk_z),
      .cout_o  (chunk_cout),
      .c_msb_o (chunk_c_msb)
   );

`ifdef OVF_DETECT_EN
   logic ovf_q;
   assign res_ovf = ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                         ovf_q <= 1'b0;
      else if (state_q == RUN && idx_q == LAST_IDX)       ovf_q <= chunk_c_msb ^ chunk_cout;
   end
`else
   logic unused_c_msb;
   assign unused_c_msb = chunk_c_msb;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         z_q     <= '0;
         idx_q   <= '0;
         sub_q   <= OP_ADD;
         id_q    <= 1'b0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         prio_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req0_ready || req1_ready) begin
                  a_q     <= acc_a_d;
                  b_q     <= acc_b_d;
                  sub_q   <= acc_sub_d;
                  id_q    <= grant;
                  carry_q <= acc_sub_d;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_q     <= a_q >> CHUNK_W;
               b_q     <= b_q >> CHUNK_W;
               z_q     <= z_d;
               carry_q <= chunk_cout;
               idx_q   <= idx_q + 1'b1;
               if (idx_q == LAST_IDX) begin
                  cout_q  <= chunk_cout;
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  prio_q  <= ~id_q;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign res_valid = valid_q;
   assign res_id    = id_q;
   assign res_z     = z_q;
   assign res_cout  = cout_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_addsub_seq_arb.sv
// tb/tb_addsub_seq_arb.sv - scoreboard bench for addsub_seq_arb (define OVF_DETECT_EN to also check res_ovf)
module tb_addsub_seq_arb;

   localparam int W = 9;
   localparam int N_CHUNK = W / 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req0_sub, req1_valid, req1_sub;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         req0_ready, req1_ready;
   logic         res_valid, res_ready, res_id, res_cout, busy;
   logic [W-1:0] res_z;
`ifdef OVF_DETECT_EN
   logic         res_ovf;
`endif

   addsub_seq_arb #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_sub   (req0_sub),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_sub   (req1_sub),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_id     (res_id),
      .res_z      (res_z),
      .res_cout   (res_cout),
`ifdef OVF_DETECT_EN
      .res_ovf    (res_ovf),
`endif
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic         id;
      logic [W-1:0] z;
      logic         cout;
      logic         ovf;
      int           exp_cyc;
   } sb_t;

   typedef struct {
      logic         id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W-1:0] z;
      logic         cout;
   } vec_t;

   sb_t  sb_q[$];
   vec_t vecs[8];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic ovf_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      logic [W-1:0] bb, s;
      bb = sub ? ~b : b;
      s  = a + bb + {{(W-1){1'b0}}, sub};
      return (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
   endfunction

   // Monitor: latency on rising res_valid, stability while stalled, compare on handshake.
   logic         prev_wait = 1'b0;
   logic         prev_id, prev_cout;
   logic [W-1:0] prev_z;
   always @(negedge clk) begin
      if (rst_n) begin
         if (res_valid && !prev_wait) begin
            if (sb_q.size() == 0) check("unexpected_result", 1, 0);
            else                  check("latency", cyc, sb_q[0].exp_cyc);
         end
         if (res_valid && prev_wait) begin
            check("stable_z", 32'(res_z), 32'(prev_z));
            check("stable_id", 32'(res_id), 32'(prev_id));
            check("stable_cout", 32'(res_cout), 32'(prev_cout));
         end
         if (res_valid && res_ready && sb_q.size() > 0) begin
            check("res_id", 32'(res_id), 32'(sb_q[0].id));
            check("res_z", 32'(res_z), 32'(sb_q[0].z));
            check("res_cout", 32'(res_cout), 32'(sb_q[0].cout));
`ifdef OVF_DETECT_EN
            check("res_ovf", 32'(res_ovf), 32'(sb_q[0].ovf));
`endif
            sb_q.pop_front();
         end
      end
      prev_wait = rst_n && res_valid && !res_ready;
      prev_id   = res_id;
      prev_z    = res_z;
      prev_cout = res_cout;
   end

   task automatic drive_req(input int which, input logic v, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic sub);
      if (which == 0) begin
         req0_valid = v; req0_a = a; req0_b = b; req0_sub = sub;
      end else begin
         req1_valid = v; req1_a = a; req1_b = b; req1_sub = sub;
      end
   endtask

   // Waits for a grant, checks which requester got it, pushes the expectation.
   task automatic accept(input int exp_id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic [W-1:0] z, input logic cout);
      sb_t e;
      bit  seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (req0_ready || req1_ready) begin
            seen = 1;
            check("grant_id", req1_ready ? 1 : 0, exp_id);
            check("one_ready", 32'(req0_ready & req1_ready), 0);
            e.id = exp_id[0]; e.z = z; e.cout = cout;
            e.ovf = ovf_model(a, b, sub);
            e.exp_cyc = cyc + 1 + N_CHUNK;
            sb_q.push_back(e);
         end
      end
      if (!seen) check("accept_timeout", 0, 1);
      @(posedge clk); #2;
   endtask

   task automatic drain();
      bit done = 0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && !busy) done = 1;
      end
      if (!done) check("drain_timeout", 0, 1);
      @(posedge clk); #2;
   endtask

   initial begin
      vecs[0] = '{1'b0, 9'd100, 9'd27,  1'b0, 9'd127, 1'b0};
      vecs[1] = '{1'b1, 9'd9,   9'd5,   1'b1, 9'd4,   1'b1};
      vecs[2] = '{1'b1, 9'd5,   9'd9,   1'b1, 9'd508, 1'b0};
      vecs[3] = '{1'b0, 9'd511, 9'd1,   1'b0, 9'd0,   1'b1};
      vecs[4] = '{1'b1, 9'd0,   9'd0,   1'b1, 9'd0,   1'b1};
      vecs[5] = '{1'b0, 9'd300, 9'd300, 1'b0, 9'd88,  1'b1};
      vecs[6] = '{1'b1, 9'd256, 9'd255, 1'b1, 9'd1,   1'b1};
      vecs[7] = '{1'b0, 9'd255, 9'd1,   1'b0, 9'd256, 1'b0};

      rst_n = 1'b0; res_ready = 1'b1;
      drive_req(0, 1'b1, 9'd10, 9'd20, 1'b0);
      drive_req(1, 1'b1, 9'd50, 9'd8, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_res_valid", 32'(res_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_res_z", 32'(res_z), 0);
      check("rst_res_cout", 32'(res_cout), 0);
      check("rst_res_id", 32'(res_id), 0);
      check("rst_req0_ready", 32'(req0_ready), 0);
      check("rst_req1_ready", 32'(req1_ready), 0);
`ifdef OVF_DETECT_EN
      check("rst_res_ovf", 32'(res_ovf), 0);
`endif
      @(posedge clk); #2;
      rst_n = 1'b1;

      // Both requesters held valid: grants must alternate starting from 0.
      for (int g = 0; g < 4; g++) begin
         if (g % 2 == 0) accept(0, 9'd10, 9'd20, 1'b0, 9'd30, 1'b0);
         else            accept(1, 9'd50, 9'd8, 1'b1, 9'd42, 1'b1);
         @(negedge clk);
         check("ready_pulse0", 32'(req0_ready), 0);
         check("ready_pulse1", 32'(req1_ready), 0);
         if (g == 3) begin
            @(posedge clk); #2;
            drive_req(0, 1'b0, '0, '0, 1'b0);
            drive_req(1, 1'b0, '0, '0, 1'b0);
         end
      end
      drain();

      for (int v = 0; v < 8; v++) begin
         drive_req(int'(vecs[v].id), 1'b1, vecs[v].a, vecs[v].b, vecs[v].sub);
         accept(int'(vecs[v].id), vecs[v].a, vecs[v].b, vecs[v].sub, vecs[v].z, vecs[v].cout);
         drive_req(int'(vecs[v].id), 1'b0, '0, '0, 1'b0);
         drain();
      end

      // Consumer stalls in DONE while requester 1 waits.
      res_ready = 1'b0;
      drive_req(0, 1'b1, 9'd1, 9'd2, 1'b0);
      accept(0, 9'd1, 9'd2, 1'b0, 9'd3, 1'b0);
      drive_req(0, 1'b0, '0, '0, 1'b0);
      drive_req(1, 1'b1, 9'd7, 9'd8, 1'b0);
      begin
         bit got = 0;
         for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = res_valid;
         end
         if (!got) check("stall_valid_timeout", 0, 1);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_res_valid", 32'(res_valid), 1);
         check("stall_req0_ready", 32'(req0_ready), 0);
         check("stall_req1_ready", 32'(req1_ready), 0);
      end
      @(posedge clk); #2;
      res_ready = 1'b1;
      @(negedge clk);
      check("hs_cycle_req1_ready", 32'(req1_ready), 0);
      accept(1, 9'd7, 9'd8, 1'b0, 9'd15, 1'b0);
      drive_req(1, 1'b0, '0, '0, 1'b0);
      drain();

      // Reset while an operation is in RUN drops it.
      drive_req(0, 1'b1, 9'd50, 9'd60, 1'b0);
      accept(0, 9'd50, 9'd60, 1'b0, 9'd110, 1'b0);
      drive_req(0, 1'b0, '0, '0, 1'b0);
      rst_n = 1'b0;
      if (sb_q.size() > 0) sb_q.delete(sb_q.size() - 1);
      @(negedge clk);
      check("midrun_rst_valid", 32'(res_valid), 0);
      check("midrun_rst_busy", 32'(busy), 0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      drive_req(1, 1'b1, 9'd3, 9'd4, 1'b0);
      accept(1, 9'd3, 9'd4, 1'b0, 9'd7, 1'b0);
      drive_req(1, 1'b0, '0, '0, 1'b0);
      drain();

      check("scoreboard_empty", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
